vec_byte_packer: RTL and testbench
==================================

# vec_byte_packer

Byte-serial to 96-bit vector assembler for the matrix multiplier datapath. Accepts matrix elements one byte at a time over a valid/ready handshake and packs up to 12 of them into a staging buffer. On completion it presents the vector on a 96-bit bus together with a one-cycle `ld` strobe. It is the write side of the 12-byte vector holding registers: `ld` and `vec_data` drive their load enable and byte inputs directly.

## Interface
- `NBYTES`, 12: bytes per vector (1..15)
- `BYTE_W`, 8: element width
- `CLK`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  `in_data` holds a byte
- `in_ready`  out  1  packer accepts a byte this cycle
- `in_data`  in  BYTE_W  element byte
- `in_last`  in  1  qualifies the accepted byte as the final byte of a short vector
- `hold`  in  1  consumer cannot load this cycle
- `ld`  out  1  one-cycle load strobe; `vec_data` is valid while high
- `vec_data`  out  NBYTES*BYTE_W  byte k at [BYTE_W*k+BYTE_W-1 : BYTE_W*k]; byte 0 is element 1
- `vec_count`  out  4  number of real bytes in `vec_data` (1..NBYTES)

## Operation
- States: FILL, ISSUE.
- FILL:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, the packer writes `in_data` to `buf[idx]` and increments `idx`.
  - If `idx == NBYTES-1` or `in_last` = 1 on the accepted byte, the packer goes to ISSUE and latches `count = idx+1`.
- ISSUE:
  - `in_ready` = 0. The producer must hold `in_valid`/`in_data` stable.
  - If `hold` = 0, at the next edge:
    - `vec_data` <= `buf` (unwritten bytes are 0)
    - `vec_count` <= `count`
    - `ld` <= 1
    - `buf`, `idx` cleared; state returns to FILL
  - If `hold` = 1, the packer stays in ISSUE indefinitely. `buf` is unchanged.
- `ld` is registered and deasserts on the edge after it rises. `ld` is never high for 2 consecutive cycles.
- `vec_data` and `vec_count` change only on the edge that raises `ld`. They remain stable until the next such edge.
- `in_last` with `in_valid` = 0 is ignored. `in_last` on byte NBYTES has the same effect as no `in_last`.
- Reset:
  - state FILL, `idx` 0, `buf` 0
  - outputs: `ld` 0, `vec_data` 0, `vec_count` 0
  - `in_ready` is forced 0 while `reset` is high.
  - Reset during ISSUE or mid-FILL discards partial data; no `ld` is produced.
- `idx`/`vec_count` width is 4 bits and never wraps, because the transition to ISSUE occurs at NBYTES.

## Timing
- Final byte accepted at edge t: ISSUE during cycle t..t+1. With `hold` = 0, `ld` is high for cycle t+1..t+2 and `in_ready` is high again from t+1.
- Minimum period is NBYTES+1 cycles per full vector.
- `hold` is sampled only in ISSUE. A stall of n cycles delays `ld` by exactly n cycles.
- The consumer loads on the falling edge inside the `ld` cycle. `vec_data` is stable for the entire cycle.
- `in_ready` is combinational from the state register and `reset` only. It has no path from `in_valid`.

## Structure
- Shared package `matmul_pkg` holds:
  - `NBYTES`, `BYTE_W`, `IDX_W` (=4)
  - state enum `pack_state_t` {FILL, ISSUE}
- Single flat module; no sub-module needed. `buf` and the `vec_data` output register are separate so that the vector on the bus never changes while the next vector fills.

## Test plan
- Reset, then 12 bytes 0x01..0x0C with `in_valid` held high, `hold` = 0:
  - `ld` pulses once, 1 cycle after byte 12
  - `vec_data` = 0x0C0B0A090807060504030201, `vec_count` = 12
  - `in_ready` low for exactly 1 cycle
- 5 bytes 0xA0..0xA4 with `in_last` on 0xA4: `vec_data` = 0x000...00A4A3A2A1A0, `vec_count` = 5.
- `hold` high for 4 cycles on completion: `ld` delayed by 4 cycles, `in_ready` low for 5 cycles, then next 12 bytes accepted. The previous `vec_data` must be unchanged until the new `ld`.
- Random gaps in `in_valid` (about 50 %) across 3 vectors: byte order is preserved, and exactly 3 `ld` pulses occur, each 1 cycle wide.
- Reset asserted after 7 bytes, then 12 bytes 0xFF:
  - no `ld` from the partial vector
  - first `ld` carries all 0xFF, `vec_count` = 12
  - outputs read 0/0/0 during reset
- Single byte 0x5A with `in_last`: `vec_count` = 1, `vec_data` = 0x5A.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared sizes and state encoding for the vector byte packer
package matmul_pkg;
  localparam int NBYTES = 12;
  localparam int BYTE_W = 8;
  localparam int IDX_W = 4;
  localparam int VEC_W = NBYTES * BYTE_W;
  typedef enum logic {FILL, ISSUE} pack_state_t;
endpackage

// File: rtl/vec_byte_packer_if.sv
// vec_byte_packer_if: byte-in handshake plus vector-out load bus
interface vec_byte_packer_if;
  import matmul_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [BYTE_W-1:0] in_data;
  logic in_last;
  logic hold;
  logic ld;
  logic [VEC_W-1:0] vec_data;
  logic [IDX_W-1:0] vec_count;
  modport master(output in_valid, in_data, in_last, hold, input in_ready, ld, vec_data, vec_count);
  modport slave(input in_valid, in_data, in_last, hold, output in_ready, ld, vec_data, vec_count);
endinterface

// File: rtl/vec_byte_packer.sv
// vec_byte_packer: packs byte-serial elements into a vector and issues it with a one-cycle ld strobe
module vec_byte_packer import matmul_pkg::*; (
  input logic CLK,
  input logic reset,
  vec_byte_packer_if.slave bus
);
  pack_state_t state, state_nx;
  logic [BYTE_W-1:0] buf_q [NBYTES];
  logic [VEC_W-1:0] buf_flat, vec_q;
  logic [IDX_W-1:0] idx, cnt_q;
  logic ld_q, accept, done, go;
  always_comb begin
    accept = (state == FILL) && bus.in_valid && !reset;
    done = accept && (bus.in_last || idx == IDX_W'(NBYTES - 1));
    go = (state == ISSUE) && !bus.hold;
    state_nx = done ? ISSUE : go ? FILL : state;
  end
  always_comb begin
    buf_flat = '0;
    for (int k = 0; k < NBYTES; k++) buf_flat[BYTE_W*k +: BYTE_W] = buf_q[k];
  end
  // idx already holds the byte count once in ISSUE, so it doubles as the latched count
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= FILL;
      idx <= '0;
      buf_q <= '{default: '0};
      ld_q <= 1'b0;
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      ld_q <= go;
      if (accept) begin
        buf_q[idx] <= bus.in_data;
        idx <= idx + IDX_W'(1);
      end
      if (go) begin
        vec_q <= buf_flat;
        cnt_q <= idx;
        buf_q <= '{default: '0};
        idx <= '0;
      end
    end
  end
  assign bus.in_ready = (state == FILL) && !reset;
  assign bus.ld = ld_q;
  assign bus.vec_data = vec_q;
  assign bus.vec_count = cnt_q;
endmodule

// File: tb/tb_vec_byte_packer.sv
// tb_vec_byte_packer: directed and randomized vectors checked against a queue-based packing model
module tb_vec_byte_packer;
  import matmul_pkg::*;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0, n_bad = 0, n_exp = 0, n_ld = 0, cyc = 0;
  logic [VEC_W-1:0] exp_v[$];
  logic [IDX_W-1:0] exp_c[$];
  logic [VEC_W-1:0] mon_v = '0;
  logic [IDX_W-1:0] mon_c = '0;
  logic ld_prev = 1'b0;
  vec_byte_packer_if bus();
  vec_byte_packer dut(.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Every ld must match the oldest modelled vector; between strobes the bus must hold the last one
  always @(negedge CLK) begin
    if (reset) ld_prev = 1'b0;
    else begin
      chk("ld_width", VEC_W'(bus.ld && ld_prev), '0);
      if (bus.ld) begin
        chk("ld_expected", VEC_W'(exp_v.size() != 0), VEC_W'(1));
        if (exp_v.size() != 0) begin
          mon_v = exp_v.pop_front();
          mon_c = exp_c.pop_front();
          n_ld++;
        end
      end
      chk("vec_data", bus.vec_data, mon_v);
      chk("vec_count", VEC_W'(bus.vec_count), VEC_W'(mon_c));
      ld_prev = bus.ld;
    end
  end
  task automatic send_byte(input logic [BYTE_W-1:0] d, input logic l, output int acc);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    @(negedge CLK);
    while (!bus.in_ready && w < 50) begin
      w++;
      @(negedge CLK);
    end
    chk("rdy_timeout", VEC_W'(w >= 50), '0);
    @(posedge CLK);
    #1;
    acc = cyc;
    bus.in_valid = 1'b0;
    bus.in_last = 1'($urandom);
    bus.in_data = BYTE_W'($urandom);
  endtask
  task automatic send_vec(input logic [BYTE_W-1:0] b[$], input bit use_last, input bit gaps, input int hold_n);
    logic [VEC_W-1:0] v = '0;
    int t = 0;
    foreach (b[i]) v[BYTE_W*i +: BYTE_W] = b[i];
    exp_v.push_back(v);
    exp_c.push_back(IDX_W'(b.size()));
    n_exp++;
    foreach (b[i]) begin
      if (gaps && $urandom_range(1) == 1) repeat ($urandom_range(3, 1)) begin
        @(posedge CLK);
        #1;
      end
      if (i == b.size() - 1) bus.hold = hold_n > 0;
      send_byte(b[i], use_last && i == b.size() - 1, t);
    end
    for (int k = 0; k <= hold_n; k++) begin
      @(negedge CLK);
      chk("rdy_low", VEC_W'(bus.in_ready), '0);
      chk("ld_wait", VEC_W'(bus.ld), '0);
    end
    bus.hold = 1'b0;
    @(negedge CLK);
    chk("rdy_back", VEC_W'(bus.in_ready), VEC_W'(1));
    chk("ld_now", VEC_W'(bus.ld), VEC_W'(1));
    chk("ld_cycle", VEC_W'(cyc), VEC_W'(t + hold_n + 1));
    @(posedge CLK);
    #1;
  endtask
  task automatic reset_check();
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_ld", VEC_W'(bus.ld), '0);
      chk("rst_vec", bus.vec_data, '0);
      chk("rst_cnt", VEC_W'(bus.vec_count), '0);
      chk("rst_rdy", VEC_W'(bus.in_ready), '0);
    end
    @(posedge CLK);
    #1;
  endtask
  initial begin
    logic [BYTE_W-1:0] q[$];
    int t;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.hold = 1'b0;
    reset_check();
    reset = 1'b0;
    q = {};
    for (int i = 1; i <= 12; i++) q.push_back(BYTE_W'(i));
    send_vec(q, 1'b0, 1'b0, 0);
    q = {};
    for (int i = 0; i < 5; i++) q.push_back(BYTE_W'(8'hA0 + i));
    send_vec(q, 1'b1, 1'b0, 0);
    for (int r = 0; r < 2; r++) begin
      q = {};
      for (int i = 0; i < NBYTES; i++) q.push_back(BYTE_W'($urandom));
      send_vec(q, r == 1, 1'b0, r == 0 ? 4 : 0);
    end
    for (int r = 0; r < 3; r++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(NBYTES, 1)); i++) q.push_back(BYTE_W'($urandom));
      send_vec(q, 1'b1, 1'b1, 0);
    end
    for (int i = 0; i < 7; i++) send_byte(BYTE_W'($urandom), 1'b0, t);
    reset = 1'b1;
    mon_v = '0;
    mon_c = '0;
    reset_check();
    reset = 1'b0;
    q = {};
    for (int i = 0; i < NBYTES; i++) q.push_back(8'hFF);
    send_vec(q, 1'b0, 1'b0, 0);
    q = {};
    q.push_back(8'h5A);
    send_vec(q, 1'b1, 1'b0, 0);
    repeat (5) @(negedge CLK);
    chk("ld_total", VEC_W'(n_ld), VEC_W'(n_exp));
    chk("drained", VEC_W'(exp_v.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
